// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-cold column drive, synchronised active-low rows, frame debounce.
// Define KEYPAD_AUTOREPEAT_EN to re-pulse o_valid every REPEAT_FRAMES frames while a key is held.
module keypad_scanner #(
  parameter int unsigned ROWS          = 4,
  parameter int unsigned COLS          = 3,
  parameter int unsigned SCAN_DIV      = 50000,
  parameter int unsigned SETTLE        = 10,
  parameter int unsigned DEBOUNCE      = 3,
  parameter int unsigned REPEAT_FRAMES = 8,
  localparam int unsigned CODE_W       = $clog2(ROWS * COLS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic [COLS-1:0]   o_col,
  input  logic [ROWS-1:0]   i_row,
  output logic [CODE_W-1:0] o_key,
  output logic              o_valid,
  output logic              o_held
);

  localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
  localparam int unsigned COL_W  = $clog2(COLS);

  typedef enum logic [1:0] {CandNone, CandKey, CandMulti} cand_e;

  logic [ROWS-1:0]   row_meta_q, row_sync_q;
  logic [SLOT_W-1:0] slot_q;
  logic [COL_W-1:0]  col_q;
  logic [COLS-1:0]   col_drv_q;
  logic [1:0]        cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d, first_code;
  logic              any_low;
  cand_e             prev_type_q, cand_type;
  logic [CODE_W-1:0] prev_code_q;
  logic [3:0]        stable_q, stable_d;
  logic              held_q, held_d, valid_q, valid_d;
  logic [CODE_W-1:0] key_q, key_d;
  logic              slot_last, frame_end, sample, same, differs, accept;

  assign slot_last = slot_q == SLOT_W'(SCAN_DIV - 1);
  assign frame_end = slot_last && (col_q == COL_W'(COLS - 1));
  assign sample    = slot_q == SLOT_W'(SETTLE);

  // Descending scan so the lowest low row wins the recorded code.
  always_comb begin
    cnt_d      = cnt_q;
    code_d     = code_q;
    first_code = '0;
    any_low    = 1'b0;
    if (sample) begin
      for (int r = ROWS - 1; r >= 0; r--) begin
        if (!row_sync_q[r]) begin
          any_low    = 1'b1;
          first_code = CODE_W'(r * COLS + int'(col_q));
          cnt_d      = (cnt_d == 2'd2) ? 2'd2 : cnt_d + 2'd1;
        end
      end
      if (any_low && cnt_q == 2'd0) code_d = first_code;
    end
  end

  always_comb begin
    unique case (cnt_d)
      2'd0:    cand_type = CandNone;
      2'd1:    cand_type = CandKey;
      default: cand_type = CandMulti;
    endcase
    same = (cand_type == prev_type_q) && (cand_type != CandKey || code_d == prev_code_q);
    if (cand_type == CandMulti) stable_d = 4'd0;
    else if (same)              stable_d = (stable_q == 4'(DEBOUNCE)) ? stable_q : stable_q + 4'd1;
    else                        stable_d = 4'd1;
    differs = (cand_type == CandKey && (!held_q || key_q != code_d)) ||
              (cand_type == CandNone && held_q);
    accept  = frame_end && cand_type != CandMulti && stable_d == 4'(DEBOUNCE) && differs;
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_FRAMES + 1);
  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_fire;

  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (frame_end) begin
      if (accept || cand_type == CandMulti) begin
        rep_d = '0;
      end else if (held_q && cand_type == CandKey && code_d == key_q) begin
        rep_d = rep_q + REP_W'(1);
        if (rep_d == REP_W'(REPEAT_FRAMES)) begin
          rep_fire = 1'b1;
          rep_d    = '0;
        end
      end else begin
        rep_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rep_q <= '0;
    else          rep_q <= rep_d;
  end
`else
  logic rep_fire;
  logic unused_repeat;
  assign rep_fire      = 1'b0;
  assign unused_repeat = ^REPEAT_FRAMES;
`endif

  always_comb begin
    held_d  = held_q;
    key_d   = key_q;
    valid_d = rep_fire;
    if (accept) begin
      if (cand_type == CandKey) begin
        key_d   = code_d;
        held_d  = 1'b1;
        valid_d = 1'b1;
      end else begin
        held_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row_meta_q  <= '1;
      row_sync_q  <= '1;
      slot_q      <= '0;
      col_q       <= '0;
      col_drv_q   <= '1;
      cnt_q       <= '0;
      code_q      <= '0;
      prev_type_q <= CandNone;
      prev_code_q <= '0;
      stable_q    <= '0;
      held_q      <= 1'b0;
      key_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      row_meta_q <= i_row;
      row_sync_q <= row_meta_q;
      if (slot_q == '0) col_drv_q <= ~(COLS'(1) << col_q);
      if (slot_last) begin
        slot_q <= '0;
        col_q  <= (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
      end else begin
        slot_q <= slot_q + SLOT_W'(1);
      end
      if (frame_end) begin
        prev_type_q <= cand_type;
        prev_code_q <= code_d;
        stable_q    <= stable_d;
        cnt_q       <= '0;
        code_q      <= '0;
      end else begin
        cnt_q  <= cnt_d;
        code_q <= code_d;
      end
      held_q  <= held_d;
      key_q   <= key_d;
      valid_q <= valid_d;
    end
  end

  assign o_col   = col_drv_q;
  assign o_key   = key_q;
  assign o_valid = valid_q;
  assign o_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: 4x3 pad, 20-cycle slots, 60-cycle frames.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  o_col;
  logic [3:0]  i_row;
  logic [3:0]  o_key;
  logic        o_valid, o_held;
  logic [11:0] keys = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS(4), .COLS(3), .SCAN_DIV(20), .SETTLE(4), .DEBOUNCE(3), .REPEAT_FRAMES(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_col(o_col), .i_row(i_row),
    .o_key(o_key), .o_valid(o_valid), .o_held(o_held)
  );

  // Pressed key at (r,c) pulls row r low while column c is driven.
  always_comb begin
    i_row = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (keys[r*3+c] && !o_col[c]) i_row[r] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs n cycles, sampling at the falling edge; reports pulse count, last pulse index and key.
  task automatic run(input int n, output int cnt, output int pos, output int key);
    cnt = 0; pos = 0; key = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); @(negedge clk);
      if (o_valid) begin cnt++; pos = i; key = int'(o_key); end
    end
  endtask

  typedef struct {
    logic [11:0] keys;
    int frames;
    int cnt;
    int pos;
    int held;
    int key;
  } step_t;

  step_t steps[15];
  int cnt, pos, key, vcnt;
  string nm;

  initial begin
    steps[0]  = '{12'h020, 3, 1, 180, 1, 5};   // key 5 accepted after 3 frames
    steps[1]  = '{12'h020, 2, 0, 0,   1, 5};   // no repeat while held
    steps[2]  = '{12'h000, 2, 0, 0,   1, 5};
    steps[3]  = '{12'h000, 1, 0, 0,   0, 5};   // release accepted, code kept
    steps[4]  = '{12'h008, 3, 1, 180, 1, 3};
    steps[5]  = '{12'h009, 4, 0, 0,   1, 3};   // multi-key: no change
    steps[6]  = '{12'h001, 2, 0, 0,   1, 3};
    steps[7]  = '{12'h001, 1, 1, 60,  1, 0};
    steps[8]  = '{12'h000, 3, 0, 0,   0, 0};
    steps[9]  = '{12'h800, 3, 1, 180, 1, 11};
    steps[10] = '{12'h004, 3, 1, 180, 1, 2};   // direct A->B change
    steps[11] = '{12'h000, 3, 0, 0,   0, 2};
`ifdef KEYPAD_AUTOREPEAT_EN
    steps[12] = '{12'h800, 20, 5, 1140, 1, 11};
`else
    steps[12] = '{12'h800, 20, 1, 180, 1, 11};
`endif
    steps[13] = '{12'h000, 3, 0, 0,   0, 11};
    steps[14] = '{12'h000, 1, 0, 0,   0, 11};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_col", int'(o_col), 7);
    check("reset_valid", int'(o_valid), 0);
    check("reset_held", int'(o_held), 0);
    check("reset_key", int'(o_key), 0);
    rst_n = 1'b1;

    // Column sequence for two frames, no key
    vcnt = 0;
    for (int e = 1; e <= 120; e++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("col_seq_%0d", e), int'(o_col), int'(~(3'b001 << (((e - 1) / 20) % 3))) & 7);
      if (o_valid || o_held) vcnt++;
    end
    check("idle_no_event", vcnt, 0);

    for (int s = 0; s < 15; s++) begin
      keys = steps[s].keys;
      run(steps[s].frames * 60, cnt, pos, key);
      check($sformatf("step%0d_cnt", s), cnt, steps[s].cnt);
      check($sformatf("step%0d_pos", s), pos, steps[s].pos);
      if (steps[s].cnt > 0) check($sformatf("step%0d_vkey", s), key, steps[s].key);
      check($sformatf("step%0d_held", s), int'(o_held), steps[s].held);
      check($sformatf("step%0d_key", s), int'(o_key), steps[s].key);
    end

    // Bounce: key 7 toggling every 50 cycles for 5 frames
    vcnt = 0;
    for (int i = 0; i < 300; i++) begin
      keys = (((i / 50) % 2) == 0) ? 12'h080 : 12'h000;
      @(posedge clk); @(negedge clk);
      if (o_valid) vcnt++;
    end
    check("bounce_no_valid", vcnt, 0);
    check("bounce_held", int'(o_held), 0);
    keys = 12'h080;
    run(180, cnt, pos, key);
    check("bounce_settle_cnt", cnt, 1);
    check("bounce_settle_pos", pos, 180);
    check("bounce_settle_key", key, 7);
    keys = 12'h000;
    run(180, cnt, pos, key);
    check("bounce_release_held", int'(o_held), 0);

    // Mid-frame reset at column 1, slot 10, with a key held
    keys = 12'h010;
    run(180, cnt, pos, key);
    check("pre_reset_valid", cnt, 1);
    check("pre_reset_key", int'(o_key), 4);
    run(30, cnt, pos, key);
    check("pre_reset_held", int'(o_held), 1);
    check("pre_reset_col", int'(o_col), 5);
    rst_n = 1'b0;
    #1;
    check("async_col", int'(o_col), 7);
    check("async_held", int'(o_held), 0);
    check("async_key", int'(o_key), 0);
    check("async_valid", int'(o_valid), 0);
    keys = 12'h000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 21; e++) begin
      @(posedge clk); @(negedge clk);
      if (e == 1 || e == 20 || e == 21) begin
        nm = $sformatf("restart_col_%0d", e);
        check(nm, int'(o_col), (e == 21) ? 5 : 6);
      end
    end
    check("restart_held", int'(o_held), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
